// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit active-low 7-segment scanner with frame latch and guard interval
module seg7_scan_ctrl #(
    parameter int SCAN_DIV  = 131072,
    parameter int GUARD_CYC = 1024,
    parameter int LZ_BLANK  = 0
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] disp_data,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  pos_ctrl,
    output logic [7:0]  num_ctrl,
    output logic        frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYC);
    localparam bit               LZ_EN     = (LZ_BLANK != 0);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_dig;
    logic [15:0]      r_shadow_data;
    logic [3:0]       r_shadow_mask;
    logic [3:0]       r_pos;
    logic [7:0]       r_num;
    logic             r_frame_done;

    logic             w_slot_end;
    logic             w_frame_start;
    logic             w_guard;
    logic [3:0]       w_nibble;
    logic [3:0]       w_lz_zero;
    logic             w_blank;
    logic [3:0]       w_pos_next;
    logic [7:0]       w_num_next;

    // Segment patterns, active-low, a in bit 7, dp (bit 0) always off.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        seg = 8'hFF;
        case (nib)
            4'h0: seg = 8'h03;
            4'h1: seg = 8'h9F;
            4'h2: seg = 8'h25;
            4'h3: seg = 8'h0D;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h49;
            4'h6: seg = 8'h41;
            4'h7: seg = 8'h1F;
            4'h8: seg = 8'h01;
            4'h9: seg = 8'h09;
            4'hA: seg = 8'h11;
            4'hB: seg = 8'hC1;
            4'hC: seg = 8'h63;
            4'hD: seg = 8'h85;
            4'hE: seg = 8'h61;
            4'hF: seg = 8'h71;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    assign w_slot_end    = (r_cnt == CNT_LAST);
    assign w_frame_start = (r_cnt == '0) && (r_dig == 2'd0);
    assign w_guard       = (r_cnt < GUARD_END);

    // A digit is a leading zero when it and every digit to its left are zero; digit 0 always shows.
    assign w_lz_zero[3] = (r_shadow_data[15:12] == 4'h0);
    assign w_lz_zero[2] = w_lz_zero[3] && (r_shadow_data[11:8] == 4'h0);
    assign w_lz_zero[1] = w_lz_zero[2] && (r_shadow_data[7:4] == 4'h0);
    assign w_lz_zero[0] = 1'b0;

    assign w_blank = r_shadow_mask[r_dig] || (LZ_EN && w_lz_zero[r_dig]);

    // Select the nibble of the latched frame word belonging to the current digit.
    always_comb begin
        w_nibble = r_shadow_data[3:0];
        case (r_dig)
            2'd0: w_nibble = r_shadow_data[3:0];
            2'd1: w_nibble = r_shadow_data[7:4];
            2'd2: w_nibble = r_shadow_data[11:8];
            2'd3: w_nibble = r_shadow_data[15:12];
            default: w_nibble = r_shadow_data[3:0];
        endcase
    end

    // Next display drive: all off during the guard part of a slot, otherwise one digit low.
    always_comb begin
        w_pos_next = 4'b1111;
        w_num_next = 8'hFF;
        if (!w_guard) begin
            w_pos_next = ~(4'b0001 << r_dig);
            w_num_next = w_blank ? 8'hFF : seg_decode(w_nibble);
        end
    end

    // Slot counter, digit pointer, frame-coherent shadow latch and registered outputs.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_cnt         <= '0;
            r_dig         <= 2'd0;
            r_shadow_data <= 16'h0000;
            r_shadow_mask <= 4'h0;
            r_pos         <= 4'b1111;
            r_num         <= 8'hFF;
            r_frame_done  <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_dig <= r_dig + 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_frame_start) begin
                r_shadow_data <= disp_data;
                r_shadow_mask <= blank_mask;
            end
            r_pos        <= w_pos_next;
            r_num        <= w_num_next;
            r_frame_done <= w_slot_end && (r_dig == 2'd3);
        end
    end

    assign pos_ctrl   = r_pos;
    assign num_ctrl   = r_num;
    assign frame_done = r_frame_done;

endmodule
